// File: rtl/mul_seq_ctrl_pkg.sv
// Shared constants for the shift-and-add multiply sequencer: ALU opcodes,
// shifter directions and the sequencer state encoding.
package mul_seq_ctrl_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_CNT_W = 6;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_LESS = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b11;

    localparam logic SFT_RIGHT = 1'b0;
    localparam logic SFT_LEFT  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADD  = 3'd1,
        ST_SHL  = 3'd2,
        ST_SHR  = 3'd3,
        ST_DONE = 3'd4
    } mul_state_e;

endpackage

// File: rtl/mul_seq_ctrl.sv
// Shift-and-add multiply sequencer driving an external ALU and Shifter;
// produces the low WIDTH bits of mcand*mplier and exits once mplier is exhausted.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src2,
    output logic             alu_invA,
    output logic             alu_invB,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             sft_lr,
    output logic [4:0]       sft_shamt,
    output logic [WIDTH-1:0] sft_src,
    input  logic [WIDTH-1:0] sft_result
);

    mul_state_e       state_q, state_d;
    logic [WIDTH-1:0] mc_q, mc_d;
    logic [WIDTH-1:0] mp_q, mp_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic [CNT_W-1:0] cntInc;

    assign cntInc = cnt_q + CNT_W'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            mc_q      <= '0;
            mp_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mc_q      <= mc_d;
            mp_q      <= mp_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mc_d      = mc_q;
        mp_d      = mp_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done      = 1'b0;
        alu_src1  = '0;
        alu_src2  = '0;
        alu_invA  = 1'b0;
        alu_invB  = 1'b0;
        alu_op    = OP_AND;
        sft_lr    = SFT_RIGHT;
        sft_shamt = 5'd0;
        sft_src   = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mc_d    = mcand_i;
                    mp_d    = mplier_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = (mplier_i == '0) ? ST_DONE : ST_ADD;
                end
            end
            ST_ADD: begin
                alu_src1 = acc_q;
                alu_src2 = mc_q;
                alu_op   = OP_ADD;
                if (mp_q[0]) begin
                    acc_d = alu_result;
                end
                state_d = ST_SHL;
            end
            ST_SHL: begin
                sft_lr    = SFT_LEFT;
                sft_shamt = 5'd1;
                sft_src   = mc_q;
                mc_d      = sft_result;
                state_d   = ST_SHR;
            end
            ST_SHR: begin
                sft_lr    = SFT_RIGHT;
                sft_shamt = 5'd1;
                sft_src   = mp_q;
                mp_d      = sft_result;
                cnt_d     = cntInc;
                // Early exit once no set multiplier bits remain.
                if (sft_result == '0 || cntInc == CNT_W'(WIDTH)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ADD;
                end
            end
            ST_DONE: begin
                product_d = acc_q;
                done      = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The fresh result is forwarded during the done cycle so it is valid with the pulse.
    assign product = (state_q == ST_DONE) ? acc_q : product_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl with behavioural ALU/Shifter models
// and a product/latency reference computed from plain arithmetic.
module tb_mul_seq_ctrl;
    import mul_seq_ctrl_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [31:0] mcand_i, mplier_i;
    logic        busy, done;
    logic [31:0] product;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic        alu_invA, alu_invB;
    logic [1:0]  alu_op;
    logic        sft_lr;
    logic [4:0]  sft_shamt;
    logic [31:0] sft_src, sft_result;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] mcand;
        logic [31:0] mplier;
        logic [31:0] expProd;
        int          expLat;
    } vec_t;

    vec_t vecs[6];

    always #5 CLK = ~CLK;

    mul_seq_ctrl dut (
        .CLK(CLK), .RST(RST), .start(start),
        .mcand_i(mcand_i), .mplier_i(mplier_i),
        .busy(busy), .done(done), .product(product),
        .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_op(alu_op),
        .alu_result(alu_result),
        .sft_lr(sft_lr), .sft_shamt(sft_shamt), .sft_src(sft_src),
        .sft_result(sft_result)
    );

    logic [31:0] aluA, aluB;
    assign aluA = alu_invA ? ~alu_src1 : alu_src1;
    assign aluB = alu_invB ? ~alu_src2 : alu_src2;
    always_comb begin
        case (alu_op)
            2'b00:   alu_result = aluA & aluB;
            2'b01:   alu_result = ($signed(aluA) < $signed(aluB)) ? 32'd1 : 32'd0;
            2'b10:   alu_result = aluA | aluB;
            default: alu_result = aluA + aluB;
        endcase
    end
    assign sft_result = sft_lr ? (sft_src << sft_shamt) : (sft_src >> sft_shamt);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int refIters(input logic [31:0] b);
        int k = 0;
        for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
        return k;
    endfunction

    // Pulses start, then follows the run and checks result, latency and unit usage.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expP, input int expLat);
        int lat = -1;
        int addCnt = 0, aluAct = 0, sftAct = 0, busyLow = 0;
        int k = expLat / 3;
        @(negedge CLK);
        start = 1'b1; mcand_i = a; mplier_i = b;
        @(negedge CLK);
        start = 1'b0;
        for (int j = 0; j < 200; j++) begin
            if (done) begin lat = j; break; end
            if (!busy) busyLow++;
            if (alu_op == OP_ADD) addCnt++;
            if (alu_op != 2'b00 || alu_src1 != 0 || alu_src2 != 0 || alu_invA || alu_invB) aluAct++;
            if (sft_lr || sft_shamt != 0 || sft_src != 0) sftAct++;
            @(negedge CLK);
        end
        checkOutput("latency", lat, expLat);
        checkOutput("product_at_done", product, expP);
        checkOutput("busy_at_done", {31'd0, busy}, 32'd1);
        checkOutput("busy_low_cycles", busyLow, 0);
        checkOutput("add_cycles", addCnt, k);
        checkOutput("alu_active_cycles", aluAct, k);
        checkOutput("sft_active_cycles", sftAct, 2 * k);
        @(negedge CLK);
        checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
        checkOutput("idle_after_done", {31'd0, busy}, 32'd0);
        checkOutput("product_held", product, expP);
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; mcand_i = '0; mplier_i = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_product", product, 32'd0);
        RST = 1'b0;

        vecs[0] = '{32'd3,        32'd5,        32'd15,         9};
        vecs[1] = '{32'h1234,     32'd0,        32'd0,          0};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,  96};
        vecs[3] = '{32'h80000000, 32'd2,        32'd0,          6};
        vecs[4] = '{32'd7,        32'h80000000, 32'h80000000,  96};
        vecs[5] = '{32'd6,        32'd1,        32'd6,          3};
        for (int i = 0; i < 6; i++)
            applyStimulus(vecs[i].mcand, vecs[i].mplier, vecs[i].expProd, vecs[i].expLat);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] a, b, p;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            p = a * b;
            applyStimulus(a, b, p, 3 * refIters(b));
        end

        // A second request while busy must be dropped.
        @(negedge CLK);
        start = 1'b1; mcand_i = 32'd6; mplier_i = 32'd7;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        start = 1'b1; mcand_i = 32'd9; mplier_i = 32'd9;
        @(negedge CLK);
        start = 1'b0;
        begin
            int seen = 0;
            for (int j = 0; j < 40; j++) begin
                if (done) begin
                    seen++;
                    checkOutput("busy_drop_product", product, 32'd42);
                    // start in the done cycle is also ignored
                    start = 1'b1; mcand_i = 32'd9; mplier_i = 32'd9;
                end else begin
                    start = 1'b0;
                end
                @(negedge CLK);
            end
            start = 1'b0;
            checkOutput("busy_drop_done_count", seen, 1);
            checkOutput("busy_drop_idle", {31'd0, busy}, 32'd0);
            checkOutput("busy_drop_product_held", product, 32'd42);
        end

        // Reset in SHL of (5,3) aborts without a done pulse.
        @(negedge CLK);
        start = 1'b1; mcand_i = 32'd5; mplier_i = 32'd3;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_product", product, 32'd0);
        begin
            int seen = 0;
            for (int j = 0; j < 10; j++) begin
                if (done) seen++;
                @(negedge CLK);
            end
            checkOutput("abort_no_done", seen, 0);
        end
        applyStimulus(32'd5, 32'd3, 32'd15, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequencer that computes an unsigned 32x32 multiply, low 32 bits of the product, using the team's shared combinational ALU and Shifter.
- Implements the shift-and-add algorithm. Each multiplier bit takes one ALU add slot and two Shifter slots.
- The ALU and Shifter are instantiated beside this block at the datapath level. This block only drives their inputs and captures their outputs.
- Exits early once the remaining multiplier is zero.

Parameters:
- WIDTH, 32, operand/product width; must match the ALU and Shifter width (32 only).
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- mcand_i  input  32  multiplicand.
- mplier_i  input  32  multiplier.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; product is valid in that cycle.
- product  output  32  low 32 bits of mcand*mplier; held until the next accepted start.
- alu_src1, alu_src2  output  32  drive ALU aluSrc1/aluSrc2.
- alu_invA, alu_invB  output  1  drive ALU invertA/invertB.
- alu_op  output  2  drive ALU operation (AND=00, LESS=01, OR=10, ADD=11).
- alu_result  input  32  ALU result.
- sft_lr  output  1  drive Shifter leftRight (1=left, 0=right).
- sft_shamt  output  5  drive Shifter shamt.
- sft_src  output  32  drive Shifter sftSrc.
- sft_result  input  32  Shifter result.

Behaviour:
- Reset (RST=1 at an edge):
  - State goes to IDLE; busy=0, done=0, product=0.
  - Internal mcand/mplier/count registers clear to 0.
  - Reset mid-operation aborts the multiply with no done pulse.
- State machine states: IDLE, ADD, SHL, SHR, DONE.
- IDLE:
  - On start=1: load mc=mcand_i, mp=mplier_i, acc=0, cnt=0.
  - If mplier_i==0, go to DONE; otherwise go to ADD.
  - start in any other state is ignored; there is no queueing.
- ADD:
  - alu_src1=acc, alu_src2=mc, alu_invA=0, alu_invB=0, alu_op=11.
  - If mp[0]=1, acc<=alu_result; otherwise acc is unchanged. The ADD cycle is spent either way.
  - Next state is SHL.
- SHL: sft_lr=1, sft_shamt=1, sft_src=mc; mc<=sft_result. Next state is SHR.
- SHR:
  - sft_lr=0, sft_shamt=1, sft_src=mp; mp<=sft_result; cnt<=cnt+1.
  - If sft_result==0 or cnt+1==WIDTH, go to DONE; otherwise go to ADD.
- DONE: product<=acc, done=1 for this single cycle; next state is IDLE.
- Idle drive values: in any state not using a unit, that unit's outputs are all 0 (alu_op=00, inv=0, srcs=0, sft_lr=0, sft_shamt=0, sft_src=0).
- Arithmetic:
  - Modulo 2^32. ALU overflow/zero outputs are not consumed.
  - Bits shifted out of mc are discarded.
- Latency: with the start-accept edge as E0 and k = index of the highest set bit of mplier plus 1, the DONE state is entered 3k edges after E0.
  - mplier==0: DONE is entered at E0, i.e. done is high in the cycle right after acceptance.
  - done is high during the cycle following that edge.
- Back-to-back requests: start in the DONE cycle is ignored. The earliest new acceptance is in the following IDLE cycle.
- product is registered and holds its value until overwritten in the DONE state.

Decomposition:
- Shared package holds:
  - ALU operation codes (OP_AND=2'b00, OP_LESS=2'b01, OP_OR=2'b10, OP_ADD=2'b11).
  - Shifter direction constants (SFT_RIGHT=0, SFT_LEFT=1).
  - State encoding for this block.
- No sub-module. A thin top, mul_seq_top, instantiates mul_seq_ctrl, ALU and Shifter for bench use.

Test Plan:
- mcand=3, mplier=5 -> product=15; done high 9 cycles after the accept edge; alu_op=11 only in the ADD cycles.
- mcand=0x1234, mplier=0 -> done high the cycle after acceptance; product=0; ALU and Shifter ports stay at 0 throughout.
- mcand=0xFFFFFFFF, mplier=0xFFFFFFFF -> product=0x00000001 after 32 iterations (96 cycles); busy high throughout.
- mcand=0x80000000, mplier=2 -> product=0 (wrap); mcand=7, mplier=0x80000000 -> product=0x80000000.
- start pulsed while busy with (9,9) during a (6,7) multiply -> product=42 only; the second request is not executed.
- RST asserted in the SHL state of (5,3) -> next cycle state=IDLE, busy=0, product=0, no done; then (5,3) -> product=15.
